// File: rtl/mprj_wb_mailbox_if.sv
// Wishbone classic bus bundle between the management SoC (master) and the
// user-project mailbox (slave).
interface mprj_wb_mailbox_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/mprj_wb_mailbox.sv
// Wishbone mailbox: CTRL/STATUS registers plus a CPU->user TX FIFO and a
// user->CPU RX FIFO, with a level interrupt into the management core.
module mprj_wb_mailbox #(
   parameter logic [31:0] BASE_ADR = 32'h3000_0000,
   parameter int          DEPTH    = 4,
   parameter int          AW       = 2
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   mprj_wb_mailbox_if.slave wbs,
   output logic [31:0]      tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   input  logic [31:0]      rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic             irq
);
   localparam int            CW       = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic          r_ack;
   logic [31:0]   r_dat;
   logic          r_en;
   logic          r_irq_en;
   logic          r_tx_ovf;
   logic          r_rx_unf;
   logic          r_irq;
   logic [31:0]   r_tx_mem [DEPTH];
   logic [31:0]   r_rx_mem [DEPTH];
   logic [AW-1:0] r_tx_wp;
   logic [AW-1:0] r_tx_rp;
   logic [AW-1:0] r_rx_wp;
   logic [AW-1:0] r_rx_rp;
   logic [CW-1:0] r_tx_cnt;
   logic [CW-1:0] r_rx_cnt;

   logic          w_hit;
   logic          w_acc;
   logic          w_wr;
   logic          w_rd;
   logic [1:0]    w_off;
   logic          w_ctrl_wr;
   logic          w_sts_clr;
   logic          w_flush;
   logic          w_tx_empty;
   logic          w_tx_full;
   logic          w_rx_empty;
   logic          w_rx_full;
   logic          w_tx_req;
   logic          w_tx_push;
   logic          w_tx_pop;
   logic          w_rx_req;
   logic          w_rx_pop;
   logic          w_rx_push;
   logic [7:0]    w_tx_cnt8;
   logic [7:0]    w_rx_cnt8;
   logic [31:0]   w_rdata;
   logic          w_unused;

   // A request is serviced only on the cycle ack is low, giving one-cycle ack pulses.
   assign w_hit     = wbs.wbs_cyc_i & wbs.wbs_stb_i & (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
   assign w_acc     = w_hit & ~r_ack;
   assign w_wr      = w_acc & wbs.wbs_we_i;
   assign w_rd      = w_acc & ~wbs.wbs_we_i;
   assign w_off     = wbs.wbs_adr_i[3:2];
   assign w_unused  = &{1'b0, wbs.wbs_adr_i[1:0]};

   assign w_ctrl_wr = w_wr & (w_off == 2'd0) & wbs.wbs_sel_i[0];
   assign w_flush   = w_wr & (w_off == 2'd0) & wbs.wbs_dat_i[2];
   assign w_sts_clr = w_wr & (w_off == 2'd1) & wbs.wbs_sel_i[0];

   assign w_tx_empty = (r_tx_cnt == {CW{1'b0}});
   assign w_tx_full  = (r_tx_cnt == FULL_CNT);
   assign w_rx_empty = (r_rx_cnt == {CW{1'b0}});
   assign w_rx_full  = (r_rx_cnt == FULL_CNT);

   // Full/empty come from pre-edge counts, so a push into a full FIFO drops even if it pops.
   assign w_tx_req  = w_wr & (w_off == 2'd2) & (wbs.wbs_sel_i != 4'h0);
   assign w_tx_push = w_tx_req & ~w_tx_full;
   assign tx_valid  = r_en & ~w_tx_empty;
   assign w_tx_pop  = tx_valid & tx_ready;
   assign tx_data   = r_tx_mem[r_tx_rp];

   assign w_rx_req  = w_rd & (w_off == 2'd3);
   assign w_rx_pop  = w_rx_req & ~w_rx_empty;
   assign rx_ready  = r_en & ~w_rx_full;
   assign w_rx_push = rx_valid & rx_ready;

   assign w_tx_cnt8 = 8'(r_tx_cnt);
   assign w_rx_cnt8 = 8'(r_rx_cnt);

   assign wbs.wbs_ack_o = r_ack;
   assign wbs.wbs_dat_o = r_dat;
   assign irq           = r_irq;

   // Read-data mux for the addressed register.
   always_comb begin
      w_rdata = 32'h0000_0000;
      case (w_off)
         2'd0:    w_rdata = {29'h0000_0000, 1'b0, r_irq_en, r_en};
         2'd1:    w_rdata = {8'h00, w_rx_cnt8, w_tx_cnt8, 2'b00, r_rx_unf, r_tx_ovf,
                             w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};
         2'd2:    w_rdata = 32'h0000_0000;
         2'd3:    w_rdata = w_rx_empty ? 32'h0000_0000 : r_rx_mem[r_rx_rp];
         default: w_rdata = 32'h0000_0000;
      endcase
   end

   // FIFO storage; contents need no reset since counts gate every read.
   always_ff @(posedge wb_clk_i) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= wbs.wbs_dat_i;
      if (w_rx_push) r_rx_mem[r_rx_wp] <= rx_data;
   end

   // Bus handshake, control/sticky registers, FIFO pointers and the interrupt.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_ack    <= 1'b0;
         r_dat    <= 32'h0000_0000;
         r_en     <= 1'b0;
         r_irq_en <= 1'b0;
         r_tx_ovf <= 1'b0;
         r_rx_unf <= 1'b0;
         r_irq    <= 1'b0;
         r_tx_wp  <= {AW{1'b0}};
         r_tx_rp  <= {AW{1'b0}};
         r_rx_wp  <= {AW{1'b0}};
         r_rx_rp  <= {AW{1'b0}};
         r_tx_cnt <= {CW{1'b0}};
         r_rx_cnt <= {CW{1'b0}};
      end else begin
         r_ack <= w_acc;
         if (w_rd) r_dat <= w_rdata;
         if (w_ctrl_wr) begin
            r_en     <= wbs.wbs_dat_i[0];
            r_irq_en <= wbs.wbs_dat_i[1];
         end
         if (w_tx_req & w_tx_full) r_tx_ovf <= 1'b1;
         else if (w_sts_clr & wbs.wbs_dat_i[4]) r_tx_ovf <= 1'b0;
         if (w_rx_req & w_rx_empty) r_rx_unf <= 1'b1;
         else if (w_sts_clr & wbs.wbs_dat_i[5]) r_rx_unf <= 1'b0;
         // Flush overrides any push or pop landing on the same edge.
         if (w_flush) begin
            r_tx_wp  <= {AW{1'b0}};
            r_tx_rp  <= {AW{1'b0}};
            r_rx_wp  <= {AW{1'b0}};
            r_rx_rp  <= {AW{1'b0}};
            r_tx_cnt <= {CW{1'b0}};
            r_rx_cnt <= {CW{1'b0}};
         end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
            if (w_rx_push) r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + AW'(1);
            r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_tx_pop);
            r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);
         end
         r_irq <= r_irq_en & (~w_rx_empty | r_tx_ovf | r_rx_unf);
      end
   end
endmodule

// File: tb/tb_mprj_wb_mailbox.sv
// Self-checking bench for mprj_wb_mailbox: directed scenarios plus a random
// mix of bus and user-side operations checked against a queue-based model.
module tb_mprj_wb_mailbox;
   localparam int          DEPTH = 4;
   localparam logic [31:0] BASE  = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [31:0] rx_data = 32'h0;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic        irq;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] tx_q[$];
   logic [31:0] rx_q[$];
   bit m_en, m_irq_en, m_ovf, m_unf;

   mprj_wb_mailbox_if bus();

   mprj_wb_mailbox #(.BASE_ADR(BASE), .DEPTH(DEPTH), .AW(2)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_status();
      logic [31:0] s;
      s = 32'h0;
      s[0] = (tx_q.size() == 0);
      s[1] = (tx_q.size() == DEPTH);
      s[2] = (rx_q.size() == 0);
      s[3] = (rx_q.size() == DEPTH);
      s[4] = m_ovf;
      s[5] = m_unf;
      s[15:8]  = 8'(tx_q.size());
      s[23:16] = 8'(rx_q.size());
      return s;
   endfunction

   function automatic logic model_irq();
      return m_irq_en && (rx_q.size() > 0 || m_ovf || m_unf);
   endfunction

   task automatic model_reset();
      tx_q.delete(); rx_q.delete();
      m_en = 0; m_irq_en = 0; m_ovf = 0; m_unf = 0;
   endtask

   task automatic idle_bus();
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
   endtask

   // One single-beat transfer; upop raises tx_ready for exactly the request edge.
   task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic upop,
                           output logic [31:0] rdata, output logic acked);
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
      bus.wbs_sel_i = sel;  bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;
      tx_ready = upop;
      @(posedge clk);
      #1;
      acked = bus.wbs_ack_o;
      rdata = bus.wbs_dat_o;
      @(negedge clk);
      idle_bus();
      tx_ready = 1'b0;
   endtask

   task automatic cpu_write(input logic [1:0] off, input logic [31:0] dat, input logic [3:0] sel,
                            input logic upop, output logic acked);
      logic [31:0] rd;
      bit pre_full, pre_valid;
      pre_full  = (tx_q.size() == DEPTH);
      pre_valid = m_en && (tx_q.size() > 0);
      bus_xfer(1'b1, BASE | {28'h0, off, 2'b00}, dat, sel, upop, rd, acked);
      case (off)
         2'd0: begin
            if (sel[0]) begin m_en = dat[0]; m_irq_en = dat[1]; end
            if (dat[2]) begin tx_q.delete(); rx_q.delete(); end
         end
         2'd1: if (sel[0]) begin
            if (dat[4]) m_ovf = 0;
            if (dat[5]) m_unf = 0;
         end
         2'd2: if (sel != 4'h0) begin
            if (pre_full) m_ovf = 1;
            else tx_q.push_back(dat);
         end
         default: ;
      endcase
      if (upop && pre_valid && !(off == 2'd0 && dat[2])) void'(tx_q.pop_front());
   endtask

   task automatic cpu_read(input logic [1:0] off, output logic [31:0] act, output logic [31:0] exp);
      logic acked;
      case (off)
         2'd0: exp = {30'h0, m_irq_en, m_en};
         2'd1: exp = model_status();
         2'd2: exp = 32'h0;
         default: begin
            if (rx_q.size() == 0) begin exp = 32'h0; m_unf = 1; end
            else exp = rx_q.pop_front();
         end
      endcase
      bus_xfer(1'b0, BASE | {28'h0, off, 2'b00}, 32'h0, 4'hF, 1'b0, act, acked);
      if (!acked) act = 32'hDEAD_DEAD;
   endtask

   task automatic rx_user_push(input logic [31:0] d, output logic r, output logic er);
      @(negedge clk);
      rx_valid = 1'b1; rx_data = d;
      r  = rx_ready;
      er = m_en && (rx_q.size() < DEPTH);
      @(posedge clk);
      @(negedge clk);
      rx_valid = 1'b0;
      if (er) rx_q.push_back(d);
   endtask

   task automatic tx_user_pop(output logic v, output logic [31:0] d, output logic ev, output logic [31:0] ed);
      @(negedge clk);
      v  = tx_valid; d = tx_data;
      ev = m_en && (tx_q.size() > 0);
      ed = ev ? tx_q[0] : 32'h0;
      tx_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_ready = 1'b0;
      if (ev) void'(tx_q.pop_front());
   endtask

   task automatic test_reset();
      bit seen;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      total++; if ({bus.wbs_ack_o, bus.wbs_dat_o, tx_valid, rx_ready, irq} !== 36'h0) begin
         bad++; $display("FAIL reset_outputs: got %h want 0", {bus.wbs_ack_o, bus.wbs_dat_o, tx_valid, rx_ready, irq}); end
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
      bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 32'h3000_0004;
      #1;
      total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL ack_early: got %b want 0", bus.wbs_ack_o); end
      @(posedge clk); #1;
      total++; if (bus.wbs_ack_o !== 1'b1) begin bad++; $display("FAIL ack_latency: got %b want 1", bus.wbs_ack_o); end
      total++; if (bus.wbs_dat_o !== 32'h0000_0005) begin bad++; $display("FAIL status_reset: got %h want 00000005", bus.wbs_dat_o); end
      @(negedge clk); idle_bus();
      @(posedge clk); #1;
      total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL ack_pulse: got %b want 0", bus.wbs_ack_o); end
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 32'h3000_0010;
      seen = 0;
      repeat (4) begin @(posedge clk); #1; if (bus.wbs_ack_o) seen = 1; end
      @(negedge clk); idle_bus();
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL miss_no_ack: got %b want 0", seen); end
   endtask

   task automatic test_tx_drain();
      logic a; logic [31:0] exp;
      logic [31:0] words [3];
      words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
      cpu_write(2'd0, 32'h3, 4'hF, 1'b0, a);
      total++; if (a !== 1'b1) begin bad++; $display("FAIL ctrl_write_ack: got %b want 1", a); end
      for (int i = 0; i < 3; i++) cpu_write(2'd2, words[i], 4'hF, 1'b0, a);
      @(negedge clk);
      tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp = tx_q.pop_front();
         total++; if ({tx_valid, tx_data} !== {1'b1, words[i]} || exp !== words[i]) begin
            bad++; $display("FAIL tx_drain%0d: got v=%b d=%h want v=1 d=%h", i, tx_valid, tx_data, words[i]); end
         @(posedge clk); @(negedge clk);
      end
      total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_drain_end: got %b want 0", tx_valid); end
      tx_ready = 1'b0;
   endtask

   task automatic test_tx_overflow();
      logic a, v, ev; logic [31:0] act, exp, d, ed;
      cpu_write(2'd0, 32'h1, 4'hF, 1'b0, a);
      for (int i = 0; i < 5; i++) cpu_write(2'd2, $urandom, 4'hF, 1'b0, a);
      cpu_read(2'd1, act, exp);
      total++; if (act !== exp) begin bad++; $display("FAIL ovf_status_model: got %h want %h", act, exp); end
      total++; if (act !== 32'h0000_0416) begin bad++; $display("FAIL ovf_status: got %h want 00000416", act); end
      cpu_write(2'd1, 32'h10, 4'h1, 1'b0, a);
      cpu_read(2'd1, act, exp);
      total++; if (act !== exp) begin bad++; $display("FAIL ovf_clear: got %h want %h", act, exp); end
      for (int i = 0; i < DEPTH; i++) begin
         tx_user_pop(v, d, ev, ed);
         total++; if (v !== ev || (ev && d !== ed)) begin
            bad++; $display("FAIL ovf_drain%0d: got v=%b d=%h want v=%b d=%h", i, v, d, ev, ed); end
      end
   endtask

   task automatic test_irq_rx();
      logic a, r, er; logic [31:0] act, exp;
      cpu_write(2'd0, 32'h3, 4'hF, 1'b0, a);
      rx_user_push(32'hA5A5_0001, r, er);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_not_yet: got %b want 0", irq); end
      @(posedge clk); @(negedge clk);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b want 1", irq); end
      cpu_read(2'd3, act, exp);
      total++; if (act !== 32'hA5A5_0001 || exp !== 32'hA5A5_0001) begin bad++; $display("FAIL rx_read: got %h want a5a50001", act); end
      @(posedge clk); @(negedge clk);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall: got %b want 0", irq); end
      cpu_read(2'd3, act, exp);
      total++; if (act !== 32'h0) begin bad++; $display("FAIL rx_unf_read: got %h want 0", act); end
      @(posedge clk); @(negedge clk);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_unf: got %b want 1", irq); end
      cpu_write(2'd1, 32'h20, 4'h1, 1'b0, a);
      @(posedge clk); @(negedge clk);
      total++; if (irq !== model_irq()) begin bad++; $display("FAIL irq_unf_clear: got %b want %b", irq, model_irq()); end
   endtask

   task automatic test_rx_full_flush();
      logic a, r, er; logic [31:0] act, exp, x;
      cpu_write(2'd0, 32'h1, 4'hF, 1'b0, a);
      cpu_read(2'd3, act, exp);
      total++; if (act !== exp) begin bad++; $display("FAIL unf_empty_read: got %h want %h", act, exp); end
      for (int i = 0; i < DEPTH; i++) begin
         rx_user_push($urandom, r, er);
         total++; if (r !== er) begin bad++; $display("FAIL rx_fill%0d: got %b want %b", i, r, er); end
      end
      x = $urandom;
      @(negedge clk);
      rx_valid = 1'b1; rx_data = x;
      total++; if (rx_ready !== 1'b0) begin bad++; $display("FAIL rx_ready_full: got %b want 0", rx_ready); end
      cpu_read(2'd3, act, exp);
      total++; if (act !== exp) begin bad++; $display("FAIL rx_full_pop: got %h want %h", act, exp); end
      @(posedge clk); @(negedge clk);
      rx_valid = 1'b0;
      rx_q.push_back(x);
      cpu_read(2'd1, act, exp);
      total++; if (act !== exp) begin bad++; $display("FAIL rx_refill_status: got %h want %h", act, exp); end
      for (int i = 0; i < 5; i++) cpu_write(2'd2, $urandom, 4'hF, 1'b0, a);
      cpu_write(2'd0, 32'h7, 4'hF, 1'b0, a);
      cpu_read(2'd1, act, exp);
      total++; if (act !== 32'h0000_0035 || exp !== 32'h0000_0035) begin bad++; $display("FAIL flush_status: got %h want 00000035", act); end
   endtask

   task automatic test_back_to_back();
      logic a, v, ev; logic [31:0] act, exp, d, ed;
      logic [3:0] pat;
      cpu_write(2'd1, 32'h30, 4'h1, 1'b0, a);
      cpu_write(2'd0, 32'h1, 4'hF, 1'b0, a);
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 32'h3000_0004;
      for (int i = 0; i < 4; i++) begin @(posedge clk); #1; pat[i] = bus.wbs_ack_o; end
      total++; if (bus.wbs_dat_o !== model_status()) begin bad++; $display("FAIL b2b_data: got %h want %h", bus.wbs_dat_o, model_status()); end
      @(negedge clk); idle_bus();
      total++; if (pat !== 4'b0101) begin bad++; $display("FAIL b2b_ack: got %b want 0101", pat); end
      cpu_write(2'd2, $urandom, 4'hF, 1'b0, a);
      cpu_write(2'd2, $urandom, 4'hF, 1'b0, a);
      cpu_write(2'd2, $urandom, 4'hF, 1'b1, a);
      cpu_read(2'd1, act, exp);
      total++; if (act !== exp) begin bad++; $display("FAIL push_pop_mid: got %h want %h", act, exp); end
      cpu_write(2'd2, $urandom, 4'h2, 1'b0, a);
      cpu_write(2'd2, $urandom, 4'h8, 1'b0, a);
      cpu_write(2'd2, $urandom, 4'hF, 1'b1, a);
      cpu_read(2'd1, act, exp);
      total++; if (act !== exp) begin bad++; $display("FAIL push_pop_full: got %h want %h", act, exp); end
      for (int i = 0; i < DEPTH; i++) begin
         tx_user_pop(v, d, ev, ed);
         total++; if (v !== ev || (ev && d !== ed)) begin
            bad++; $display("FAIL b2b_order%0d: got v=%b d=%h want v=%b d=%h", i, v, d, ev, ed); end
      end
   endtask

   task automatic test_disable();
      logic a, v, ev, r, er; logic [31:0] act, exp, d, ed;
      cpu_write(2'd1, 32'h30, 4'h1, 1'b0, a);
      cpu_write(2'd0, 32'h1, 4'hF, 1'b0, a);
      cpu_write(2'd2, $urandom, 4'hF, 1'b0, a);
      cpu_write(2'd2, $urandom, 4'hF, 1'b0, a);
      cpu_write(2'd0, 32'h0, 4'hF, 1'b0, a);
      tx_user_pop(v, d, ev, ed);
      total++; if (v !== ev) begin bad++; $display("FAIL dis_tx_valid: got %b want %b", v, ev); end
      rx_user_push($urandom, r, er);
      total++; if (r !== er) begin bad++; $display("FAIL dis_rx_ready: got %b want %b", r, er); end
      cpu_write(2'd2, $urandom, 4'hF, 1'b0, a);
      cpu_read(2'd1, act, exp);
      total++; if (act !== exp) begin bad++; $display("FAIL dis_status: got %h want %h", act, exp); end
      cpu_write(2'd0, 32'h1, 4'hF, 1'b0, a);
      for (int i = 0; i < 3; i++) begin
         tx_user_pop(v, d, ev, ed);
         total++; if (v !== ev || (ev && d !== ed)) begin
            bad++; $display("FAIL dis_order%0d: got v=%b d=%h want v=%b d=%h", i, v, d, ev, ed); end
      end
   endtask

   task automatic test_random();
      logic a, v, ev, r, er; logic [31:0] act, exp, d, ed;
      for (int i = 0; i < 120; i++) begin
         case ($urandom_range(0, 5))
            0: cpu_write(2'd2, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), a);
            1: begin
               cpu_read(2'd1, act, exp);
               total++; if (act !== exp) begin bad++; $display("FAIL rnd_status%0d: got %h want %h", i, act, exp); end
               total++; if (irq !== model_irq()) begin bad++; $display("FAIL rnd_irq%0d: got %b want %b", i, irq, model_irq()); end
            end
            2: begin
               rx_user_push($urandom, r, er);
               total++; if (r !== er) begin bad++; $display("FAIL rnd_rx_ready%0d: got %b want %b", i, r, er); end
            end
            3: begin
               cpu_read(2'($urandom_range(0, 3)), act, exp);
               total++; if (act !== exp) begin bad++; $display("FAIL rnd_read%0d: got %h want %h", i, act, exp); end
            end
            4: begin
               tx_user_pop(v, d, ev, ed);
               total++; if (v !== ev || (ev && d !== ed)) begin
                  bad++; $display("FAIL rnd_pop%0d: got v=%b d=%h want v=%b d=%h", i, v, d, ev, ed); end
            end
            default: begin
               if ($urandom_range(0, 1) == 1)
                  cpu_write(2'd0, {29'h0, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0)},
                            4'($urandom_range(0, 15)), 1'b0, a);
               else
                  cpu_write(2'd1, {26'h0, 2'($urandom_range(0, 3)), 4'hF}, 4'($urandom_range(0, 15)), 1'b0, a);
            end
         endcase
      end
   endtask

   task automatic test_reset_midflight();
      logic a, r, er; bit seen; logic [31:0] act, exp;
      cpu_write(2'd0, 32'h3, 4'hF, 1'b0, a);
      cpu_write(2'd2, $urandom, 4'hF, 1'b0, a);
      rx_user_push($urandom, r, er);
      cpu_read(2'd1, act, exp);
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 32'h3000_0004;
      rst = 1'b1;
      #1;
      total++; if ({bus.wbs_ack_o, bus.wbs_dat_o, tx_valid, rx_ready, irq} !== 36'h0) begin
         bad++; $display("FAIL rst_async: got %h want 0", {bus.wbs_ack_o, bus.wbs_dat_o, tx_valid, rx_ready, irq}); end
      seen = 0;
      repeat (2) begin @(posedge clk); #1; if (bus.wbs_ack_o) seen = 1; end
      @(negedge clk);
      idle_bus();
      rst = 1'b0;
      model_reset();
      @(posedge clk); #1; if (bus.wbs_ack_o) seen = 1;
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_no_ack: got %b want 0", seen); end
      cpu_read(2'd1, act, exp);
      total++; if (act !== exp) begin bad++; $display("FAIL rst_status: got %h want %h", act, exp); end
   endtask

   initial begin
      idle_bus();
      model_reset();
      test_reset();
      test_tx_drain();
      test_tx_overflow();
      test_irq_rx();
      test_rx_full_flush();
      test_back_to_back();
      test_disable();
      test_random();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
